// File: rtl/scale_arbiter.sv
// scale_arbiter -- three-requester round-robin front end for one shared
// fixed-point scaler (a * b >>> SN).
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active high
//   req_valid  [2:0]     per-requester operand pair valid
//   req_ready  [2:0]     per-requester accept strobe (one-hot or zero, IDLE only)
//   a_in       [3*N-1:0] packed signed multiplicands, requester i at [i*N +: N]
//   b_in       [3*N-1:0] packed signed coefficients, same packing
//   out_valid            result available
//   out_ready            downstream accepts result
//   out_data   [N-1:0]   scaled product, bits [N+SN-1:SN] of the full product
//   out_id     [1:0]     requester that owns out_data
//   busy                 high whenever the engine is not idle
//
// One operation is in flight at a time: accept (IDLE->CALC), compute
// (CALC->HOLD, out_valid rises), handshake (HOLD->IDLE). After a handshake the
// priority pointer moves past the requester just served.

// Per-requester grant decision. A requester wins when it is valid and no
// valid requester sits ahead of it in the rotation that starts at ptr.
module scale_arbiter_lane #(
  parameter int IDX = 0
) (
  input  logic [1:0] ptr,
  input  logic [2:0] valid,
  output logic       grant
);

  // Distance from the pointer in the 0..2 rotation; smaller wins.
  function automatic int rank_of(input int j, input logic [1:0] p);
    return (j + 3 - int'(p)) % 3;
  endfunction

  always_comb begin
    grant = valid[IDX];
    for (int j = 0; j < 3; j++) begin
      if (j != IDX && valid[j] && (rank_of(j, ptr) < rank_of(IDX, ptr)))
        grant = 1'b0;
    end
  end

endmodule

module scale_arbiter #(
  parameter int N  = 20,
  parameter int SN = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  input  logic [3*N-1:0]   a_in,
  input  logic [3*N-1:0]   b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_id,
  output logic             busy
);

  localparam int NREQ = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]      state;
  logic [1:0]      ptr;
  logic [1:0]      id_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [1:0]      sel;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [2*N-1:0]  prod;
  logic            prod_unused;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    scale_arbiter_lane #(.IDX(i)) u_lane (
      .ptr   (ptr),
      .valid (req_valid),
      .grant (grant[i])
    );
  end

  // Grants are only offered in IDLE; reset masks them so nothing is
  // accepted while reset is held.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  // Operand/id mux driven by the one-hot accept strobe.
  always_comb begin
    sel   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel   = 2'(i);
        a_sel = a_in[i*N +: N];
        b_sel = b_in[i*N +: N];
      end
    end
  end

  // Sign-extend both operands to 2N; the low 2N bits of the unsigned
  // product then equal the two's complement product.
  assign prod = {{N{a_q[N-1]}}, a_q} * {{N{b_q[N-1]}}, b_q};

  // Bits above N+SN-1 are dropped on purpose (wrap, no saturation) and the
  // bits below SN are the floor truncation.
  assign prod_unused = ^{prod[2*N-1:N+SN], prod[SN-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      id_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            a_q   <= a_sel;
            b_q   <= b_sel;
            id_q  <= sel;
            state <= CALC;
          end
        end
        CALC: begin
          out_data  <= prod[N+SN-1:SN];
          out_id    <= id_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= (out_id == 2'd2) ? 2'd0 : out_id + 2'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
